// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader. Receives a framed byte stream over a simple
// valid/ready channel, writes the payload into the CPU program memory and
// releases the CPU from reset once a complete frame with a correct checksum
// has been loaded.
//
// Frame:  HEADER, LEN (1..DEPTH), LEN data bytes, CSUM
//         CSUM = sum of the data bytes modulo 256.
//
// Bytes before a HEADER are discarded. A bad length or checksum puts the
// loader in an error state, where it keeps the CPU in reset and waits for a
// new HEADER. Once running, the loader ignores the channel until reset.
//
// Parameters
//   HEADER       frame start byte
//   DEPTH        program memory depth in bytes (address port is 5 bits)
//
// Ports
//   clk_i        single clock, all state changes on the rising edge
//   reset        synchronous, active-low reset
//   rx_data_i    incoming byte
//   rx_valid_i   rx_data_i is valid
//   rx_ready_o   loader accepts a byte (transfer = rx_valid_i && rx_ready_o)
//   mem_we_o     program memory write strobe, one cycle per data byte
//   mem_addr_o   program memory write address
//   mem_wdata_o  program memory write data
//   cpu_reset_o  active-high CPU reset, held until a valid frame is loaded
//   load_done_o  valid program loaded, CPU running
//   load_err_o   last frame rejected
//
// All outputs come straight from flops; nothing on rx_* reaches an output
// without passing through a register.
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter logic [7:0]  HEADER = 8'hA5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic       clk_i,
    input  logic       reset,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic       mem_we_o,
    output logic [4:0] mem_addr_o,
    output logic [7:0] mem_wdata_o,
    output logic       cpu_reset_o,
    output logic       load_done_o,
    output logic       load_err_o
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        RUN,
        ERR
    } state_t;

    // Largest legal LEN, sized to compare directly against a received byte.
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t     state;
    state_t     state_next;
    logic [7:0] len_q;
    logic [7:0] len_next;
    logic [4:0] index_q;
    logic [4:0] index_next;
    logic [7:0] sum_q;
    logic [7:0] sum_next;

    logic       transfer;
    logic       last_byte;
    logic       len_bad;
    logic       data_write;

    // rx_ready_o is itself a flop, so the handshake uses only registered state
    // on the loader side.
    assign transfer   = rx_valid_i && rx_ready_o;

    // index counts 0..LEN-1; the LEN-th byte is the one arriving at LEN-1.
    // With LEN = 32 the index wraps to 0 after the last byte, which is
    // harmless because the state has already moved on to CSUM.
    assign last_byte  = ({3'b000, index_q} == (len_q - 8'd1));

    assign len_bad    = (rx_data_i == 8'd0) || (rx_data_i > DEPTH_B);

    assign data_write = transfer && (state == DATA);

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that paths
        // which do not assign it hold the value instead of inferring a latch.
        state_next = state;
        len_next   = len_q;
        index_next = index_q;
        sum_next   = sum_q;

        unique case (state)
            IDLE: begin
                if (transfer && (rx_data_i == HEADER)) begin
                    state_next = LEN;
                end
            end

            LEN: begin
                if (transfer) begin
                    if (len_bad) begin
                        state_next = ERR;
                    end else begin
                        len_next   = rx_data_i;
                        index_next = 5'd0;
                        sum_next   = 8'd0;
                        state_next = DATA;
                    end
                end
            end

            DATA: begin
                // A byte equal to HEADER here is plain payload, not a resync.
                if (transfer) begin
                    sum_next   = sum_q + rx_data_i;
                    index_next = index_q + 5'd1;
                    if (last_byte) begin
                        state_next = CSUM;
                    end
                end
            end

            CSUM: begin
                if (transfer) begin
                    state_next = (rx_data_i == sum_q) ? RUN : ERR;
                end
            end

            RUN: begin
                // Left only through reset.
                state_next = RUN;
            end

            ERR: begin
                if (transfer && (rx_data_i == HEADER)) begin
                    state_next = LEN;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, regardless of statement order.
        if (!reset) begin
            state   <= IDLE;
            len_q   <= 8'd0;
            index_q <= 5'd0;
            sum_q   <= 8'd0;
        end else begin
            state   <= state_next;
            len_q   <= len_next;
            index_q <= index_next;
            sum_q   <= sum_next;
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    //
    // Status outputs are decoded from state_next so they change on the same
    // edge as the state itself: e.g. load_done_o rises and cpu_reset_o falls
    // on the edge that accepts the checksum byte.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset) begin
            rx_ready_o  <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 5'd0;
            mem_wdata_o <= 8'd0;
            cpu_reset_o <= 1'b1;
            load_done_o <= 1'b0;
            load_err_o  <= 1'b0;
        end else begin
            rx_ready_o  <= (state_next != RUN);
            mem_we_o    <= data_write;
            cpu_reset_o <= (state_next != RUN);
            load_done_o <= (state_next == RUN);
            load_err_o  <= (state_next == ERR);

            // Address and data only move with a write so the memory bus
            // stays quiet between strobes.
            if (data_write) begin
                mem_addr_o  <= index_q;
                mem_wdata_o <= rx_data_i;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Directed bench for prog_loader. Inputs change on the falling edge, outputs
// are sampled on the falling edge, i.e. half a cycle away from the active
// edge. A monitor logs every memory write strobe so each frame's writes can be
// compared against hand-computed address/data lists.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    logic       clk_i;
    logic       reset;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ready_o;
    logic       mem_we_o;
    logic [4:0] mem_addr_o;
    logic [7:0] mem_wdata_o;
    logic       cpu_reset_o;
    logic       load_done_o;
    logic       load_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Write log filled by the monitor.
    int         wr_cnt = 0;
    logic [4:0] wr_addr [0:255];
    logic [7:0] wr_data [0:255];

    prog_loader #(
        .HEADER (8'hA5),
        .DEPTH  (32)
    ) dut (
        .clk_i       (clk_i),
        .reset       (reset),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .cpu_reset_o (cpu_reset_o),
        .load_done_o (load_done_o),
        .load_err_o  (load_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // A strobe seen on consecutive falling edges means consecutive writes, so
    // a stretched strobe shows up as an extra (duplicate) log entry.
    always @(negedge clk_i) begin
        if (mem_we_o && wr_cnt < 256) begin
            wr_addr[wr_cnt] = mem_addr_o;
            wr_data[wr_cnt] = mem_wdata_o;
            wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge. Presents one byte and holds it until the
    // loader is ready; returns on the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited     = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        check("ready_timeout", 32'(waited >= 20), 32'd0);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(rx_ready_o),  32'd0);
        check({tag, "_we"},    32'(mem_we_o),    32'd0);
        check({tag, "_addr"},  32'(mem_addr_o),  32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata_o), 32'd0);
        check({tag, "_cpurst"},32'(cpu_reset_o), 32'd1);
        check({tag, "_done"},  32'(load_done_o), 32'd0);
        check({tag, "_err"},   32'(load_err_o),  32'd0);
    endtask

    // Pulse reset for one rising edge, check reset values, then check that
    // rx_ready_o rises on the first edge with reset high.
    task automatic apply_reset(input string tag);
        reset      = 1'b0;
        rx_valid_i = 1'b0;
        @(negedge clk_i);
        check_reset_values(tag);
        reset = 1'b1;
        @(negedge clk_i);
        check({tag, "_ready_rise"}, 32'(rx_ready_o), 32'd1);
    endtask

    // Compare the log entry at index idx against an expected write.
    task automatic check_write(input string tag, input int idx,
                               input logic [4:0] addr, input logic [7:0] data);
        check({tag, "_addr"}, 32'(wr_addr[idx]), 32'(addr));
        check({tag, "_data"}, 32'(wr_data[idx]), 32'(data));
    endtask

    initial begin
        int base;
        logic [7:0] garbage [0:2];
        logic [7:0] frame6  [0:6];

        reset      = 1'b0;
        rx_data_i  = 8'h00;
        rx_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // ---- Reset state ---------------------------------------------------
        check_reset_values("rst0");
        reset = 1'b1;
        @(negedge clk_i);
        check("rst0_ready_rise", 32'(rx_ready_o), 32'd1);
        check("rst0_cpurst_hold", 32'(cpu_reset_o), 32'd1);

        // ---- Basic frame: A5,03,10,20,30,60 --------------------------------
        base = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        check("basic_cpurst_before", 32'(cpu_reset_o), 32'd1);
        check("basic_done_before",   32'(load_done_o), 32'd0);
        send_byte(8'h60);
        check("basic_cpurst_after", 32'(cpu_reset_o), 32'd0);
        check("basic_done_after",   32'(load_done_o), 32'd1);
        check("basic_ready_run",    32'(rx_ready_o),  32'd0);
        check("basic_err",          32'(load_err_o),  32'd0);
        idle(2);
        check("basic_nwr", 32'(wr_cnt - base), 32'd3);
        check_write("basic_w0", base + 0, 5'h00, 8'h10);
        check_write("basic_w1", base + 1, 5'h01, 8'h20);
        check_write("basic_w2", base + 2, 5'h02, 8'h30);

        // ---- Bad checksum then recovery ------------------------------------
        apply_reset("rst1");
        base = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'hFF);
        check("csum_err_set",    32'(load_err_o),  32'd1);
        check("csum_err_cpurst", 32'(cpu_reset_o), 32'd1);
        check("csum_err_done",   32'(load_done_o), 32'd0);
        check("csum_err_ready",  32'(rx_ready_o),  32'd1);
        idle(2);
        check("csum_err_nwr", 32'(wr_cnt - base), 32'd2);
        check_write("csum_err_w0", base + 0, 5'h00, 8'h01);
        check_write("csum_err_w1", base + 1, 5'h01, 8'h02);
        base = wr_cnt;
        send_byte(8'hA5);
        check("recover_err_clear", 32'(load_err_o), 32'd0);
        send_byte(8'h01);
        send_byte(8'h07);
        send_byte(8'h07);
        check("recover_done",   32'(load_done_o), 32'd1);
        check("recover_cpurst", 32'(cpu_reset_o), 32'd0);
        idle(2);
        check("recover_nwr", 32'(wr_cnt - base), 32'd1);
        check_write("recover_w0", base, 5'h00, 8'h07);

        // ---- Illegal lengths: 00 and 21 ------------------------------------
        apply_reset("rst2");
        base = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        check("len0_err", 32'(load_err_o), 32'd1);
        send_byte(8'hA5);
        check("len_rehdr_err_clear", 32'(load_err_o), 32'd0);
        send_byte(8'h21);
        check("len21_err",    32'(load_err_o),  32'd1);
        check("len21_cpurst", 32'(cpu_reset_o), 32'd1);
        idle(2);
        check("badlen_nwr", 32'(wr_cnt - base), 32'd0);

        // ---- Full-depth frame: 32 bytes 00..1F, CSUM F0 --------------------
        apply_reset("rst3");
        base = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h20);
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        send_byte(8'hF0);
        check("full_done", 32'(load_done_o), 32'd1);
        idle(2);
        check("full_nwr", 32'(wr_cnt - base), 32'd32);
        for (int i = 0; i < 32; i++) begin
            check_write($sformatf("full_w%0d", i), base + i, 5'(i), 8'(i));
        end

        // ---- Garbage, HEADER inside payload, random gaps, RUN lockout ------
        // Data 11,A5,22,33: sum = 0x10B -> CSUM 0B.
        apply_reset("rst4");
        garbage[0] = 8'h00; garbage[1] = 8'hFF; garbage[2] = 8'h3C;
        frame6[0] = 8'hA5; frame6[1] = 8'h04; frame6[2] = 8'h11; frame6[3] = 8'hA5;
        frame6[4] = 8'h22; frame6[5] = 8'h33; frame6[6] = 8'h0B;
        base = wr_cnt;
        for (int i = 0; i < 3; i++) send_byte(garbage[i]);
        check("garbage_err", 32'(load_err_o), 32'd0);
        for (int i = 0; i < 7; i++) begin
            idle(int'($urandom_range(0, 3)));
            send_byte(frame6[i]);
        end
        check("gaps_done",  32'(load_done_o), 32'd1);
        check("gaps_ready", 32'(rx_ready_o),  32'd0);
        idle(2);
        check("gaps_nwr", 32'(wr_cnt - base), 32'd4);
        check_write("gaps_w0", base + 0, 5'h00, 8'h11);
        check_write("gaps_w1", base + 1, 5'h01, 8'hA5);
        check_write("gaps_w2", base + 2, 5'h02, 8'h22);
        check_write("gaps_w3", base + 3, 5'h03, 8'h33);
        base = wr_cnt;
        rx_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rx_data_i = (i == 0) ? 8'hA5 : 8'(8'h40 + i);
            @(negedge clk_i);
            check("run_ready_low", 32'(rx_ready_o), 32'd0);
        end
        idle(2);
        check("run_nwr",  32'(wr_cnt - base), 32'd0);
        check("run_done", 32'(load_done_o),   32'd1);

        // ---- Reset in the middle of DATA -----------------------------------
        apply_reset("rst5");
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'h02);
        apply_reset("middata");
        idle(1);
        base = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hAA);
        check("after_rst_done",   32'(load_done_o), 32'd1);
        check("after_rst_cpurst", 32'(cpu_reset_o), 32'd0);
        idle(2);
        check("after_rst_nwr", 32'(wr_cnt - base), 32'd1);
        check_write("after_rst_w0", base, 5'h00, 8'hAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
